// File: rtl/jtframe_ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM state encoding,
// common keyboard command bytes and the frame parity helper.
package jtframe_ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAITIDLE
  } ps2_tx_state_t;

  // Keyboard command bytes
  localparam logic [7:0] ED = 8'hED;  // set LEDs
  localparam logic [7:0] F4 = 8'hF4;  // enable scanning
  localparam logic [7:0] FF = 8'hFF;  // reset

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/jtframe_ps2_sync.sv
// Conditions one asynchronous PS/2 pad input: 2-FF synchronizer, 3-sample
// majority deglitch filter and falling-edge detector on the filtered level.
// Ports:
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_pad        : raw pad level (asynchronous)
//   o_filt       : synchronized, filtered level (idles high)
//   o_fall       : 1 while filtered level was 1 last cycle and is 0 now
module jtframe_ps2_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_filt,
  output logic o_fall
);

  logic r_meta, r_sync, r_h1, r_h2, r_filt, r_filt_d;
  logic w_maj;

  assign w_maj = (r_sync & r_h1) | (r_sync & r_h2) | (r_h1 & r_h2);

  // Reset to the released (high) bus level so no fall is seen out of reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_h1     <= 1'b1;
      r_h2     <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_meta   <= i_pad;
      r_sync   <= r_meta;
      r_h1     <= r_sync;
      r_h2     <= r_h1;
      r_filt   <= w_maj;
      r_filt_d <= r_filt;
    end
  end

  assign o_filt = r_filt;
  assign o_fall = r_filt_d & ~r_filt;

endmodule

// File: rtl/jtframe_ps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the open-drain PS/2 clock/data lines and checks the device ACK.
// Ports:
//   clk, rst                : system clock, asynchronous active-high reset
//   ps2_clk_in, ps2_data_in : pad inputs (asynchronous)
//   ps2_clk_oe, ps2_data_oe : 1 = pull the line low, 0 = release
//   tx_data, tx_valid       : byte and send request, taken when tx_ready
//   tx_ready                : high only in IDLE
//   busy                    : high outside IDLE; gates the PS/2 receiver
//   done, err               : 1-cycle pulses, ACK received / failed frame
module jtframe_ps2_tx #(
  parameter int CLK_KHZ    = 48000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import jtframe_ps2_pkg::*;

  localparam int INH_CYC = CLK_KHZ * INHIBIT_US / 1000;
  localparam int TO_CYC  = CLK_KHZ * TIMEOUT_MS;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  ps2_tx_state_t    r_state;
  logic             r_clk_oe, r_data_oe, r_done, r_err;
  logic [9:0]       r_frame;   // {stop, parity, d7..d0}, shifted out LSB first
  logic [3:0]       r_bitcnt;
  logic [INH_W-1:0] r_inh;
  logic [TO_W-1:0]  r_to;

  logic w_clk, w_fall, w_dat, w_dat_fall_unused, w_to_run;

  jtframe_ps2_sync u_sync_clk (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pad  (ps2_clk_in),
    .o_filt (w_clk),
    .o_fall (w_fall)
  );

  jtframe_ps2_sync u_sync_dat (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pad  (ps2_data_in),
    .o_filt (w_dat),
    .o_fall (w_dat_fall_unused)
  );

  assign w_to_run = (r_state == REQ) || (r_state == SHIFT) ||
                    (r_state == ACK) || (r_state == WAITIDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_frame   <= '1;
      r_bitcnt  <= '0;
      r_inh     <= '0;
      r_to      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_to_run) r_to <= r_to + 1'b1;

      // Timeout is checked ahead of the per-state logic so it wins over a fall
      if (w_to_run && r_to == TO_LAST) begin
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_err     <= 1'b1;
        r_state   <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (tx_valid) begin
              r_frame  <= {1'b1, odd_parity(tx_data), tx_data};
              r_bitcnt <= '0;
              r_inh    <= '0;
              r_to     <= '0;
              r_clk_oe <= 1'b1;
              r_state  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (r_inh == INH_LAST) begin
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b1;  // start bit
              r_to      <= '0;
              r_state   <= REQ;
            end else begin
              r_inh <= r_inh + 1'b1;
            end
          end
          REQ: begin
            if (w_fall) begin
              r_data_oe <= ~r_frame[0];
              r_frame   <= {1'b1, r_frame[9:1]};
              r_bitcnt  <= 4'd1;
              r_state   <= SHIFT;
            end
          end
          SHIFT: begin
            // Stop bit is a 1 in the frame, so it releases data like any other bit
            if (w_fall) begin
              r_data_oe <= ~r_frame[0];
              r_frame   <= {1'b1, r_frame[9:1]};
              r_bitcnt  <= r_bitcnt + 1'b1;
              if (r_bitcnt == 4'd9) r_state <= ACK;
            end
          end
          ACK: begin
            if (w_fall) begin
              if (!w_dat) r_done <= 1'b1;
              else        r_err  <= 1'b1;
              r_state <= WAITIDLE;
            end
          end
          WAITIDLE: begin
            if (w_clk && w_dat) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign err         = r_err;
  assign tx_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_jtframe_ps2_tx.sv
// Directed bench for jtframe_ps2_tx with a behavioural PS/2 keyboard model.
// The clock is scaled to 1 MHz so frames stay short: inhibit = 100 cycles,
// timeout = 15000 cycles, device clock 12.5 kHz = 80 cycles per bit.
module tb_jtframe_ps2_tx;

  localparam int INH  = 100;    // 1000 kHz * 100 us / 1000
  localparam int TO   = 15000;  // 1000 kHz * 15 ms
  localparam int HALF = 40;     // half period of the device clock

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err;
  logic       dev_clk_lo = 1'b0;
  logic       dev_data_lo = 1'b0;
  logic       clk_line, data_line;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_total = 0, err_total = 0, both_total = 0;
  int done_cyc = 0, err_cyc = 0;

  // Open-drain bus: either side may pull a line low
  assign clk_line  = ~(ps2_clk_oe | dev_clk_lo);
  assign data_line = ~(ps2_data_oe | dev_data_lo);

  jtframe_ps2_tx #(
    .CLK_KHZ    (1000),
    .INHIBIT_US (100),
    .TIMEOUT_MS (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin done_total++; done_cyc = cyc; end
    if (err)  begin err_total++;  err_cyc  = cyc; end
    if (done && err) both_total++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; leaves tx_valid low at the following negedge
  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts cycles with the clock inhibited until the host releases it
  task automatic wait_req(output int hi_cnt, output int rq_cyc, output bit ok);
    hi_cnt = 0;
    rq_cyc = 0;
    ok     = 1'b0;
    for (int i = 0; i < 4 * INH + 50; i++) begin
      if (ps2_clk_oe) hi_cnt++;
      else if (hi_cnt > 0) begin
        rq_cyc = cyc;
        ok     = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Device generates npulse clocks, reads data on each rising edge and,
  // when ack is set, pulls data low after the 10th rise for the ACK bit.
  task automatic dev_clock(input int npulse, input bit ack,
                           output logic [9:0] bits, output int f11);
    bits = '0;
    f11  = 0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < npulse; k++) begin
      dev_clk_lo = 1'b1;
      if (k == 10) f11 = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_lo = 1'b0;
      if (k < 10) bits[k] = data_line;
      if (k == 9 && ack) dev_data_lo = 1'b1;
      if (k == 10) dev_data_lo = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [9:0] exp_bits, input string tag);
    int hi, rq, f11, d0, e0;
    bit ok;
    logic [9:0] got;
    d0 = done_total;
    e0 = err_total;
    send(b);
    chk1({tag, "_latency"}, ps2_clk_oe, 1'b1);
    wait_req(hi, rq, ok);
    chk1({tag, "_req_seen"}, ok, 1'b1);
    chkv({tag, "_inhibit_len"}, 32'(hi), INH);
    chk1({tag, "_start_bit"}, ps2_data_oe, 1'b1);
    chk1({tag, "_ready_low"}, tx_ready, 1'b0);
    dev_clock(11, 1'b1, got, f11);
    repeat (20) @(negedge clk);
    chkv({tag, "_bits"}, 32'(got), 32'(exp_bits));
    chkv({tag, "_done_cnt"}, done_total - d0, 1);
    chkv({tag, "_err_cnt"}, err_total - e0, 0);
    chkv({tag, "_done_cyc"}, done_cyc, f11 + 5);
    chk1({tag, "_ready_end"}, tx_ready, 1'b1);
  endtask

  initial begin
    int hi, rq, f11, d0, e0;
    bit ok;
    logic [9:0] got;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("rst_data_oe", ps2_data_oe, 1'b0);
    chk1("rst_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1. 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    run_frame(8'hED, 10'h3ED, "ed");

    // 2. parity of 0x01 is 0, of 0x00 is 1
    run_frame(8'h01, 10'h201, "x01");
    run_frame(8'h00, 10'h300, "x00");

    // 3. device never ACKs
    d0 = done_total;
    e0 = err_total;
    send(8'hED);
    wait_req(hi, rq, ok);
    chk1("nack_req_seen", ok, 1'b1);
    dev_clock(11, 1'b0, got, f11);
    repeat (20) @(negedge clk);
    chkv("nack_bits", 32'(got), 32'h3ED);
    chkv("nack_err_cnt", err_total - e0, 1);
    chkv("nack_done_cnt", done_total - d0, 0);
    chkv("nack_err_cyc", err_cyc, f11 + 5);
    chk1("nack_ready", tx_ready, 1'b1);

    // 4. device stops after 4 clocks: timeout from REQ entry
    d0 = done_total;
    e0 = err_total;
    send(8'h00);
    wait_req(hi, rq, ok);
    chk1("to_req_seen", ok, 1'b1);
    dev_clock(4, 1'b0, got, f11);
    chk1("to_data_driven", ps2_data_oe, 1'b1);
    for (int i = 0; i < TO + 200 && err_total == e0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chkv("to_err_cnt", err_total - e0, 1);
    chkv("to_err_cyc", err_cyc, rq + TO);
    chk1("to_clk_oe", ps2_clk_oe, 1'b0);
    chk1("to_data_oe", ps2_data_oe, 1'b0);
    chk1("to_ready", tx_ready, 1'b1);
    chkv("to_done_cnt", done_total - d0, 0);

    // 5. request held with a new byte during a frame
    d0 = done_total;
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h55;
    wait_req(hi, rq, ok);
    chk1("hold_req_seen", ok, 1'b1);
    chk1("hold_ready_low", tx_ready, 1'b0);
    dev_clock(11, 1'b1, got, f11);
    chkv("hold_first_bits", 32'(got), 32'h2F4);
    repeat (20) @(negedge clk);
    chkv("hold_first_done", done_total - d0, 1);
    wait_req(hi, rq, ok);
    chk1("hold_second_req", ok, 1'b1);
    tx_valid = 1'b0;
    dev_clock(11, 1'b1, got, f11);
    repeat (20) @(negedge clk);
    chkv("hold_second_bits", 32'(got), 32'h355);
    chkv("hold_done_cnt", done_total - d0, 2);
    chk1("hold_ready_end", tx_ready, 1'b1);

    // 6. async reset mid-SHIFT, then a clean 0xFF
    send(8'h00);
    wait_req(hi, rq, ok);
    dev_clock(3, 1'b0, got, f11);
    chk1("arst_pre_data_oe", ps2_data_oe, 1'b1);
    chk1("arst_pre_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("arst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("arst_data_oe", ps2_data_oe, 1'b0);
    chk1("arst_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_frame(8'hFF, 10'h3FF, "ff");

    chkv("done_err_overlap", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
